// File: rtl/ifu_icache_dm.sv
// ifu_icache_dm: direct-mapped I-cache with burst refill and fence.i flush; ICACHE_PERF_EN adds hit/miss counters
module ifu_icache_dm #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SET_BITS  = 4,
  parameter int WORD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_pc,
  input  logic              flush,
  output logic [ADDR_W-1:0] bus_araddr,
  output logic              bus_arvalid,
  input  logic              bus_arready,
  output logic [7:0]        bus_arlen,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
`ifdef ICACHE_PERF_EN
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss,
`endif
  input  logic              bus_rlast
);
  localparam int TAG_W = ADDR_W - SET_BITS - WORD_BITS - 2;
  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_BITS;
  typedef enum logic [1:0] {IDLE, AR, FILL, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-3:0] pc_q;
  logic [WORD_BITS:0] beat_q;
  logic flushed_q;
  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [DATA_W-1:0] data_q [SETS*WORDS];
  logic [DATA_W-1:0] rsp_inst_q;
  logic [ADDR_W-1:0] rsp_pc_q;
  logic [WORD_BITS-1:0] req_word, fill_word;
  logic [SET_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic accept, hit, beat_fire, done, full_line;
  assign req_word  = req_pc[WORD_BITS+1:2];
  assign req_idx   = req_pc[WORD_BITS+SET_BITS+1:WORD_BITS+2];
  assign req_tag   = req_pc[ADDR_W-1:WORD_BITS+SET_BITS+2];
  assign fill_word = pc_q[WORD_BITS-1:0];
  assign fill_idx  = pc_q[WORD_BITS+SET_BITS-1:WORD_BITS];
  assign fill_tag  = pc_q[ADDR_W-3:WORD_BITS+SET_BITS];
  assign accept    = req_valid && req_ready;
  assign hit       = valid_q[req_idx] && tag_q[req_idx] == req_tag;
  assign beat_fire = state_q == FILL && bus_rvalid;
  assign done      = beat_fire && bus_rlast;
  // a line is only trusted when rlast lands exactly on the final beat
  assign full_line = beat_q == (WORD_BITS+1)'(WORDS-1);
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = hit ? RESP : AR;
      AR:      if (bus_arready) state_d = FILL;
      FILL:    if (done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready   = state_q == IDLE;
    rsp_valid   = state_q == RESP;
    bus_arvalid = state_q == AR;
    bus_araddr  = {pc_q[ADDR_W-3:WORD_BITS], {(WORD_BITS+2){1'b0}}};
    bus_arlen   = 8'(WORDS-1);
    rsp_inst    = rsp_inst_q;
    rsp_pc      = rsp_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      pc_q       <= '0;
      beat_q     <= '0;
      flushed_q  <= 1'b0;
      rsp_inst_q <= '0;
      rsp_pc_q   <= '0;
    end else begin
      if (accept) begin
        pc_q      <= req_pc[ADDR_W-1:2];
        rsp_pc_q  <= req_pc;
        beat_q    <= '0;
        flushed_q <= 1'b0;
        if (hit) rsp_inst_q <= data_q[{req_idx, req_word}];
      end
      if (state_q == AR) rsp_inst_q <= '0;
      if (beat_fire) begin
        beat_q <= beat_q + (WORD_BITS+1)'(!beat_q[WORD_BITS]);
        if (beat_q == {1'b0, fill_word}) rsp_inst_q <= bus_rdata;
        if (bus_rlast) valid_q[fill_idx] <= full_line && !flushed_q;
      end
      if (flush && (state_q == AR || state_q == FILL)) flushed_q <= 1'b1;
      if (flush) valid_q <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && beat_fire && !beat_q[WORD_BITS]) data_q[{fill_idx, beat_q[WORD_BITS-1:0]}] <= bus_rdata;
    if (!rst && done) tag_q[fill_idx] <= fill_tag;
  end
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_hit_q  <= perf_hit_q + 32'(accept && hit && !(&perf_hit_q));
      perf_miss_q <= perf_miss_q + 32'(accept && !hit && !(&perf_miss_q));
    end
  end
  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif
endmodule

// File: tb/tb_ifu_icache_dm.sv
// tb_ifu_icache_dm: directed table plus corner-case sequences for ifu_icache_dm
module tb_ifu_icache_dm;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, flush = 1'b0;
  logic [31:0] req_pc = '0, rsp_inst, rsp_pc, bus_araddr, bus_rdata = '0;
  logic bus_arvalid, bus_arready = 1'b0, bus_rvalid = 1'b0, bus_rlast = 1'b0;
  logic [7:0] bus_arlen;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit, perf_miss;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ifu_icache_dm dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_pc(rsp_pc),
    .flush(flush), .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
    .bus_arlen(bus_arlen), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
`ifdef ICACHE_PERF_EN
    .perf_hit(perf_hit), .perf_miss(perf_miss),
`endif
    .bus_rlast(bus_rlast)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // bus model: beat i of a burst at address A returns {A[15:0], 8'h00, (i+1)*0x11}
  task automatic run_req(input logic [31:0] pc, input bit fl_acc, input bit fl_fill,
                         output bit miss, output logic [31:0] addr, output logic [7:0] len,
                         output logic [31:0] inst, output logic [31:0] rpc, output bit tmo);
    int n;
    miss = 1'b0; addr = '0; len = '0; tmo = 1'b0;
    req_valid = 1'b1; req_pc = pc; flush = fl_acc;
    step();
    req_valid = 1'b0; flush = 1'b0; req_pc = 32'hDEAD_BEE0;
    if (!rsp_valid) begin
      miss = 1'b1; addr = bus_araddr; len = bus_arlen;
      step();
      chk("araddr_stable", bus_araddr, addr);
      bus_arready = 1'b1;
      step();
      bus_arready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        bus_rvalid = 1'b1; bus_rlast = (i == 3); flush = fl_fill && i == 1;
        bus_rdata = {addr[15:0], 8'h00, 8'((i + 1) * 17)};
        step();
      end
      bus_rvalid = 1'b0; bus_rlast = 1'b0; flush = 1'b0;
    end
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    tmo = !rsp_valid;
    inst = rsp_inst; rpc = rsp_pc;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask
  typedef struct {
    logic [31:0] pc;
    bit          fl_before;
    bit          miss;
    logic [31:0] addr;
    logic [31:0] inst;
  } vec_t;
  vec_t tbl [10];
  task automatic req_check(input string tag, input logic [31:0] pc, input bit fl_acc, input bit fl_fill,
                           input bit w_miss, input logic [31:0] w_addr, input logic [31:0] w_inst);
    bit miss, tmo;
    logic [31:0] addr, inst, rpc;
    logic [7:0] len;
    run_req(pc, fl_acc, fl_fill, miss, addr, len, inst, rpc, tmo);
    chk({tag, "_timeout"}, 32'(tmo), 32'd0);
    chk({tag, "_miss"}, 32'(miss), 32'(w_miss));
    if (w_miss) begin
      chk({tag, "_araddr"}, addr, w_addr);
      chk({tag, "_arlen"}, 32'(len), 32'd3);
    end
    chk({tag, "_inst"}, inst, w_inst);
    chk({tag, "_pc"}, rpc, pc);
  endtask
  initial begin
    tbl[0] = '{32'h8000_0004, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0022};
    tbl[1] = '{32'h8000_000C, 1'b0, 1'b0, 32'h0,         32'h0000_0044};
    tbl[2] = '{32'h8000_0000, 1'b0, 1'b0, 32'h0,         32'h0000_0011};
    tbl[3] = '{32'h8000_0404, 1'b0, 1'b1, 32'h8000_0400, 32'h0400_0022};
    tbl[4] = '{32'h8000_0004, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0022};
    tbl[5] = '{32'h8000_0008, 1'b0, 1'b0, 32'h0,         32'h0000_0033};
    tbl[6] = '{32'h8000_0400, 1'b1, 1'b1, 32'h8000_0400, 32'h0400_0011};
    tbl[7] = '{32'h8000_0010, 1'b0, 1'b1, 32'h8000_0010, 32'h0010_0011};
    tbl[8] = '{32'h8000_001C, 1'b0, 1'b0, 32'h0,         32'h0010_0044};
    tbl[9] = '{32'h8000_0400, 1'b0, 1'b0, 32'h0,         32'h0400_0011};
    repeat (2) step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_arvalid", 32'(bus_arvalid), 32'd0);
    chk("rst_rsp_inst", rsp_inst, 32'd0);
    chk("rst_rsp_pc", rsp_pc, 32'd0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].fl_before) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      req_check($sformatf("vec%0d", i), tbl[i].pc, 1'b0, 1'b0, tbl[i].miss, tbl[i].addr, tbl[i].inst);
    end
    // back-pressure: response must hold and no new request may slip in
    req_valid = 1'b1; req_pc = 32'h8000_0014;
    step();
    req_pc = 32'h8000_0040;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_inst", rsp_inst, 32'h0010_0022);
      chk("bp_rsp_pc", rsp_pc, 32'h8000_0014);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_after_valid", 32'(rsp_valid), 32'd0);
    chk("bp_after_arvalid", 32'(bus_arvalid), 32'd0);
    // flush coinciding with a hit, then flush during a refill
    req_check("flush_acc", 32'h8000_0018, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0010_0033);
    req_check("flush_acc_re", 32'h8000_0018, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0010_0033);
    req_check("flush_fill", 32'h8000_0020, 1'b0, 1'b1, 1'b1, 32'h8000_0020, 32'h0020_0011);
    req_check("flush_fill_re", 32'h8000_0020, 1'b0, 1'b0, 1'b1, 32'h8000_0020, 32'h0020_0011);
`ifdef ICACHE_PERF_EN
    chk("perf_hit", perf_hit, 32'd7);
    chk("perf_miss", perf_miss, 32'd8);
`endif
    // reset in the middle of a refill
    req_valid = 1'b1; req_pc = 32'h8000_0044;
    step();
    req_valid = 1'b0;
    chk("mid_arvalid", 32'(bus_arvalid), 32'd1);
    bus_arready = 1'b1;
    step();
    bus_arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_0000 + 32'(i);
      step();
    end
    bus_rvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_arvalid", 32'(bus_arvalid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
`ifdef ICACHE_PERF_EN
    chk("mid_rst_perf_hit", perf_hit, 32'd0);
    chk("mid_rst_perf_miss", perf_miss, 32'd0);
`endif
    for (int i = 0; i < 2; i++) begin
      bus_rvalid = 1'b1; bus_rlast = (i == 1); bus_rdata = 32'hBAD1_0000;
      step();
    end
    bus_rvalid = 1'b0; bus_rlast = 1'b0;
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    req_check("post_rst", 32'h8000_0044, 1'b0, 1'b0, 1'b1, 32'h8000_0040, 32'h0040_0022);
    req_check("post_rst_cold", 32'h8000_0014, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0010_0022);
    req_check("post_rst_hit", 32'h8000_004C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0044);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifu_icache_dm.md
Name: ifu_icache_dm

Overview:
- Parametrised direct-mapped L1 instruction cache with multi-word lines and burst refill; sits between the PC/fetch stage and the instruction bus master.
- Adds the following:
  - configurable set count and line size;
  - a proper tag compare (hit = valid AND tag match);
  - ready/valid on both the request and response sides;
  - burst refill with `rlast`;
  - `flush` (fence.i).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction/bus word width; fixed at 32 (byte offset = 2 bits).
- SET_BITS, 4, log2(number of sets); 16 sets.
- WORD_BITS, 2, log2(words per line); 4 words per line.
- TAG_W, ADDR_W-SET_BITS-WORD_BITS-2, derived tag width; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  fetch request valid
- req_ready  out  1  cache can accept a request
- req_pc  in  ADDR_W  fetch address; word-aligned, bits [1:0] ignored
- rsp_valid  out  1  instruction valid
- rsp_ready  in  1  downstream accepts the instruction
- rsp_inst  out  DATA_W  fetched instruction
- rsp_pc  out  ADDR_W  PC of `rsp_inst`
- flush  in  1  invalidate all lines
- bus_araddr  out  ADDR_W  burst start address; line-aligned
- bus_arvalid  out  1  read address valid
- bus_arready  in  1  read address accepted
- bus_arlen  out  8  beats minus 1 = 2^WORD_BITS-1
- bus_rdata  in  DATA_W  read beat data
- bus_rvalid  in  1  read beat valid; the cache is always ready for beats
- bus_rlast  in  1  final beat of the burst

Behaviour:
- Address split: offset = pc[1:0], word = pc[WORD_BITS+1:2], index = pc[WORD_BITS+SET_BITS+1:WORD_BITS+2], tag = remaining upper bits.
- Storage: data array, tag array, and one valid bit per set.
- Reset: all valid bits = 0, state = IDLE, rsp_valid = 0, bus_arvalid = 0, rsp_inst = 0, rsp_pc = 0. req_ready = 1 from the first cycle after reset.
- FSM states:
  - IDLE: req_ready = 1. A request is accepted when req_valid & req_ready; the PC is latched.
    - Hit: rsp_inst and rsp_pc are registered, rsp_valid = 1 in the next cycle, go to RESP. Hit latency is 1 cycle.
    - Miss: go to AR.
  - AR: bus_arvalid = 1 with bus_araddr = {tag,index,WORD_BITS+2 zero bits}. On bus_arready, go to FILL. bus_araddr and bus_arvalid stay stable until accepted.
  - FILL: each bus_rvalid beat writes data[index][beat_cnt]; beat_cnt starts at 0 and increments.
    - When beat_cnt equals the requested word, that beat is also captured into rsp_inst.
    - On rvalid & rlast: tag is written; valid bit set unless a flush occurred during this refill; go to RESP with rsp_valid = 1 in the next cycle.
    - If rlast arrives before 2^WORD_BITS beats, or does not arrive on the last beat, the refilled line is left invalid. rsp_inst is still delivered if the requested word was received, otherwise 0.
  - RESP: rsp_valid = 1 and req_ready = 0. rsp_inst and rsp_pc are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE. No back-to-back acceptance in the handshake cycle.
- Flush:
  - In any state: clears all valid bits in the same clock edge.
  - During AR/FILL: the burst is completed (never abandoned) but the line is not validated; the response is still delivered.
  - Flush in the same cycle as a hit acceptance in IDLE: the lookup uses the pre-flush valid bits; the response is delivered; all lines are invalid afterwards.
- Reset mid-refill: FSM returns to IDLE, arvalid drops, and outstanding beats are ignored. Bus-side cleanup is the interconnect's responsibility.
- req_pc is sampled only on acceptance; changes at other times are ignored.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined:
  - Adds outputs perf_hit and perf_miss (32-bit each).
  - perf_hit increments on each accepted request that hits; perf_miss on each accepted request that misses.
  - Both counters saturate at 0xFFFFFFFF, reset to 0, and are not cleared by flush.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: req_pc = 0x80000004, bus returns beats 0x11,0x22,0x33,0x44 with rlast on the 4th.
  - Required response: bus_araddr = 0x80000000, bus_arlen = 3, rsp_inst = 0x22, rsp_pc = 0x80000004.
- Hit after fill:
  - Stimulus: req_pc = 0x8000000C next.
  - Required response: no bus_arvalid; rsp_valid one cycle after acceptance; rsp_inst = 0x44.
- Conflict:
  - Stimulus: req_pc = 0x80000404 (same index, different tag, defaults).
  - Required response: miss, refill; a later 0x80000004 misses again.
- Flush:
  - Stimulus: flush pulse, then req_pc = 0x80000400.
  - Required response: miss and refill issued.
  - Stimulus: flush asserted during FILL.
  - Required response: response delivered; immediate re-request of the same PC misses.
- Back-pressure:
  - Stimulus: rsp_ready held 0 for 5 cycles.
  - Required response: rsp_valid, rsp_inst and rsp_pc stable; req_ready = 0; no new request accepted.
- Reset:
  - Stimulus: rst asserted mid-FILL.
  - Required response: next cycle rsp_valid = 0, bus_arvalid = 0, req_ready = 1. With ICACHE_PERF_EN, perf_hit = perf_miss = 0.
